dm_ws: RTL and testbench
========================

Name: dm_ws

Overview:
- Next-generation data memory for the processor datapath: byte-addressed, little-endian, 32-bit data.
- Supports byte, halfword and word accesses, with sign or zero extension on loads.
- Uses a req/ready handshake with a parametrised number of wait states, so the core can be moved to a multicycle or stalled pipeline.
- Flags misaligned or reserved accesses instead of silently aliasing them.

Parameters:
ADDR_W, 7, byte-address width; depth = 2^(ADDR_W-2) words of 32 bits (default 32 words)
WAIT, 0, wait states inserted before completion (0..15); latency = WAIT+1 cycles

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
req  input  1  access request, sampled only when block is accepting
we  input  1  1 = store, 0 = load (sampled with req)
addr  input  ADDR_W  byte address (sampled with req)
size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
uns  input  1  1 = zero-extend loads, 0 = sign-extend (ignored for word/store)
wd  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
ready  output  1  one-cycle completion pulse
rd  output  32  load result, valid when ready=1, held until next completion
fault  output  1  error for the completing access, valid with ready, held like rd
busy  output  1  access in flight (request not accepted)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ready=0, rd=0, fault=0, busy=0, wait counter=0.
  - Memory array is not cleared.
- States: IDLE, WAIT, DONE.
- Acceptance:
  - req is accepted at a rising edge when state is IDLE or DONE.
  - On acceptance, addr/we/size/uns/wd are latched into internal registers. Inputs need not be held afterwards.
  - req while busy=1 is ignored. It is not queued, so the requester must re-present it.
- Transitions:
  - IDLE/DONE with req: if WAIT=0 go to DONE; else go to WAIT with counter=WAIT-1.
  - WAIT: decrement the counter each cycle; at counter=0 go to DONE.
  - DONE without req: go to IDLE.
- ready=1 exactly during the DONE cycle. Latency from the accepting edge to ready is WAIT+1 cycles.
- Back-to-back: a req accepted in DONE gives a throughput of one access per WAIT+1 cycles.
- busy=1 in WAIT. busy=0 in IDLE and DONE.
- Fault and alignment:
  - Fault condition is any of: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=00.
  - On a fault: no memory write occurs, rd=0, fault=1 with ready.
  - On a good access: fault=0.
- Store commit:
  - Memory is updated on the edge that enters DONE.
  - Only the addressed lanes are written. Byte: lane addr[1:0] gets wd[7:0]. Half: lanes addr[1]*2 and +1 get wd[15:0]. Word: all four lanes.
  - Other lanes are untouched.
  - rd after a store is 0.
- Load capture:
  - rd is registered on the edge that enters DONE, from memory contents at that time.
  - Byte/half are extracted from the addressed lane(s) and extended to 32 bits per uns.
- Word index = addr[ADDR_W-1:2]. Full range is addressable, with no out-of-range case.
- Reset mid-operation: a request in WAIT is aborted and its store is dropped (not committed). Outputs go to reset values.
- No read-during-write hazard exists, since one access is in flight at a time.

Test Plan:
1. WAIT=0: word store 0xDEADBEEF to addr 0x08, then word load from 0x08. Expected: ready one cycle after each req; rd=0xDEADBEEF; fault=0.
2. Byte/half with extension: store word 0x11223344 to 0x10, then store byte 0x80 to 0x11.
   - Signed byte load from 0x11 gives rd=0xFFFFFF80.
   - Unsigned byte load from 0x11 gives 0x00000080.
   - Signed half load from 0x12 gives 0x00001122.
   - Word load from 0x10 gives 0x11228044.
3. Faults:
   - Half store at 0x03 gives ready with fault=1 and rd=0; a following word load from 0x00 shows the word unchanged.
   - size=11 also faults.
4. WAIT=3: req load at cycle 0. Expected: busy=1 for cycles 1-3 and ready at cycle 4. A second req at cycle 2 is ignored (exactly one ready). A req held high in the DONE cycle is accepted and its ready arrives 4 cycles later.
5. Reset mid-operation: WAIT=3, word store 0xCAFEF00D to 0x04, rst_n low at cycle 2. Expected: outputs 0 immediately; after release, word load from 0x04 returns the prior content, not 0xCAFEF00D.
6. Sweep: every word index 0..31 written with value index*0x01010101 then read back. Expected: all match and no aliasing.

Source files
------------

// File: rtl/dm_ws.sv
// dm_ws: byte-addressed, little-endian 32-bit data memory with a req/ready
// handshake, WAIT configurable wait states and fault reporting for misaligned/reserved sizes.
module dm_ws #(
    parameter int ADDR_W = 7,
    parameter int WAIT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [31:0]       wd,
    output logic              ready,
    output logic [31:0]       rd,
    output logic              fault,
    output logic              busy
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              accept, complete;

    logic [ADDR_W-1:0] l_addr;
    logic              l_we;
    logic [1:0]        l_size;
    logic              l_uns;
    logic [31:0]       l_wd;

    logic [ADDR_W-1:0] op_addr;
    logic              op_we;
    logic [1:0]        op_size;
    logic              op_uns;
    logic [31:0]       op_wd;
    logic              op_fault;

    logic [3:0]        lane_en;
    logic [31:0]       lane_data;
    logic [31:0]       word, shifted, load_val;

    logic [31:0]       mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        complete  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT == 0) begin
                        state_nxt = ST_DONE;
                        complete  = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = 4'(WAIT - 1);
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_DONE;
                    complete  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_addr <= '0;
            l_we   <= 1'b0;
            l_size <= 2'b00;
            l_uns  <= 1'b0;
            l_wd   <= '0;
        end else if (accept) begin
            l_addr <= addr;
            l_we   <= we;
            l_size <= size;
            l_uns  <= uns;
            l_wd   <= wd;
        end
    end

    // With no wait states the access completes on its accepting edge, so the
    // live inputs are the operands; otherwise the latched copy is used.
    always_comb begin
        if (state == ST_WAIT) begin
            op_addr = l_addr;
            op_we   = l_we;
            op_size = l_size;
            op_uns  = l_uns;
            op_wd   = l_wd;
        end else begin
            op_addr = addr;
            op_we   = we;
            op_size = size;
            op_uns  = uns;
            op_wd   = wd;
        end
    end

    always_comb begin
        op_fault  = (op_size == 2'b11) ||
                    (op_size == 2'b01 && op_addr[0]) ||
                    (op_size == 2'b10 && op_addr[1:0] != 2'b00);
        lane_en   = 4'b1111;
        lane_data = op_wd;
        case (op_size)
            2'b00: begin
                lane_en   = 4'b0001 << op_addr[1:0];
                lane_data = {4{op_wd[7:0]}};
            end
            2'b01: begin
                lane_en   = op_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{op_wd[15:0]}};
            end
            default: begin
                lane_en   = 4'b1111;
                lane_data = op_wd;
            end
        endcase
    end

    always_comb begin
        word     = mem[op_addr[ADDR_W-1:2]];
        shifted  = word >> {op_addr[1:0], 3'b000};
        load_val = word;
        case (op_size)
            2'b00:   load_val = {{24{~op_uns & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{~op_uns & shifted[15]}}, shifted[15:0]};
            default: load_val = word;
        endcase
    end

    // The rst_n term drops a store whose completing edge coincides with reset.
    always_ff @(posedge clk) begin
        if (rst_n && complete && op_we && !op_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[op_addr[ADDR_W-1:2]][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd    <= '0;
            fault <= 1'b0;
        end else if (complete) begin
            rd    <= (op_fault || op_we) ? 32'h0 : load_val;
            fault <= op_fault;
        end
    end

    assign ready = (state == ST_DONE);
    assign busy  = (state == ST_WAIT);

endmodule

// File: tb/tb_dm_ws.sv
// tb_dm_ws: directed bench for dm_ws; dut0 runs with no wait states, dut3 with
// three, each with its own req and reset.
module tb_dm_ws;
    logic        clk = 1'b0;
    logic        rst_n0, rst_n3;
    logic        req0, req3;
    logic        we;
    logic [6:0]  addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wd;
    logic        ready0, ready3, fault0, fault3, busy0, busy3;
    logic [31:0] rd0, rd3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dm_ws #(.ADDR_W(7), .WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n0), .req(req0), .we(we), .addr(addr),
        .size(size), .uns(uns), .wd(wd), .ready(ready0), .rd(rd0),
        .fault(fault0), .busy(busy0)
    );

    dm_ws #(.ADDR_W(7), .WAIT(3)) dut3 (
        .clk(clk), .rst_n(rst_n3), .req(req3), .we(we), .addr(addr),
        .size(size), .uns(uns), .wd(wd), .ready(ready3), .rd(rd3),
        .fault(fault3), .busy(busy3)
    );

    typedef struct {
        logic        w;
        logic [6:0]  a;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_f;
    } vec_t;

    vec_t vecs[18];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issues one request on the selected DUT and waits (bounded) for ready.
    task automatic applyStimulus(input bit sel, input logic w, input logic [6:0] a,
                                 input logic [1:0] sz, input logic u, input logic [31:0] d,
                                 output logic [31:0] r, output logic f, output int lat);
        @(negedge clk);
        we = w; addr = a; size = sz; uns = u; wd = d;
        if (sel) req3 = 1'b1; else req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; req3 = 1'b0;
        lat = 1;
        while (!(sel ? ready3 : ready0) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = sel ? rd3 : rd0;
        f = sel ? fault3 : fault0;
    endtask

    initial begin
        logic [31:0] r;
        logic        f;
        int          lat;
        int          cnt;

        vecs[0]  = '{1'b1, 7'h08, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 7'h08, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 7'h10, 2'b10, 1'b0, 32'h11223344, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 7'h11, 2'b00, 1'b0, 32'hAAAAAA80, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 7'h11, 2'b00, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[5]  = '{1'b0, 7'h11, 2'b00, 1'b1, 32'h0,        32'h00000080, 1'b0};
        vecs[6]  = '{1'b0, 7'h12, 2'b01, 1'b0, 32'h0,        32'h00001122, 1'b0};
        vecs[7]  = '{1'b0, 7'h10, 2'b10, 1'b0, 32'h0,        32'h11228044, 1'b0};
        vecs[8]  = '{1'b1, 7'h00, 2'b10, 1'b0, 32'hA5A55A5A, 32'h0,        1'b0};
        vecs[9]  = '{1'b1, 7'h03, 2'b01, 1'b0, 32'h0000FFFF, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 7'h00, 2'b10, 1'b0, 32'h0,        32'hA5A55A5A, 1'b0};
        vecs[11] = '{1'b1, 7'h00, 2'b11, 1'b0, 32'h0,        32'h0,        1'b1};
        vecs[12] = '{1'b0, 7'h00, 2'b11, 1'b0, 32'h0,        32'h0,        1'b1};
        vecs[13] = '{1'b0, 7'h02, 2'b10, 1'b0, 32'h0,        32'h0,        1'b1};
        vecs[14] = '{1'b1, 7'h16, 2'b01, 1'b0, 32'h1234BEEF, 32'h0,        1'b0};
        vecs[15] = '{1'b0, 7'h16, 2'b01, 1'b0, 32'h0,        32'hFFFFBEEF, 1'b0};
        vecs[16] = '{1'b0, 7'h16, 2'b01, 1'b1, 32'h0,        32'h0000BEEF, 1'b0};
        vecs[17] = '{1'b0, 7'h00, 2'b10, 1'b0, 32'h0,        32'hA5A55A5A, 1'b0};

        rst_n0 = 1'b0; rst_n3 = 1'b0; req0 = 1'b0; req3 = 1'b0;
        we = 1'b0; addr = '0; size = 2'b00; uns = 1'b0; wd = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready0", 32'(ready0), 32'd0);
        checkOutput("reset_busy0",  32'(busy0),  32'd0);
        checkOutput("reset_rd0",    rd0,         32'd0);
        checkOutput("reset_fault0", 32'(fault0), 32'd0);
        checkOutput("reset_ready3", 32'(ready3), 32'd0);
        checkOutput("reset_busy3",  32'(busy3),  32'd0);
        @(negedge clk);
        rst_n0 = 1'b1; rst_n3 = 1'b1;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b0, vecs[i].w, vecs[i].a, vecs[i].sz, vecs[i].u, vecs[i].d, r, f, lat);
            checkOutput($sformatf("vec%0d_rd", i),    r,        vecs[i].exp_rd);
            checkOutput($sformatf("vec%0d_fault", i), 32'(f),   32'(vecs[i].exp_f));
            checkOutput($sformatf("vec%0d_lat", i),   32'(lat), 32'd1);
        end

        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b1, 7'(i * 4), 2'b10, 1'b0, 32'(i) * 32'h01010101, r, f, lat);
        end
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b0, 7'(i * 4), 2'b10, 1'b0, 32'h0, r, f, lat);
            checkOutput($sformatf("sweep%0d", i), r, 32'(i) * 32'h01010101);
        end

        applyStimulus(1'b1, 1'b1, 7'h04, 2'b10, 1'b0, 32'h12345678, r, f, lat);
        checkOutput("w3_store_lat", 32'(lat), 32'd4);

        // Second request mid-flight must be dropped.
        @(negedge clk);
        we = 1'b0; addr = 7'h04; size = 2'b10; uns = 1'b0; req3 = 1'b1;
        @(posedge clk); #1;
        req3 = 1'b0;
        checkOutput("w3_c1_busy",  32'(busy3),  32'd1);
        checkOutput("w3_c1_ready", 32'(ready3), 32'd0);
        @(posedge clk); #1;
        checkOutput("w3_c2_busy", 32'(busy3), 32'd1);
        addr = 7'h08; req3 = 1'b1;
        @(posedge clk); #1;
        req3 = 1'b0;
        checkOutput("w3_c3_busy", 32'(busy3), 32'd1);
        @(posedge clk); #1;
        checkOutput("w3_c4_ready", 32'(ready3), 32'd1);
        checkOutput("w3_c4_busy",  32'(busy3),  32'd0);
        checkOutput("w3_c4_rd",    rd3,         32'h12345678);
        cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ready3) cnt++;
        end
        checkOutput("w3_ignored_extra_ready", 32'(cnt), 32'd0);

        // req held high through DONE is accepted back-to-back.
        @(negedge clk);
        we = 1'b0; addr = 7'h04; size = 2'b10; req3 = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ready3 && lat < 20);
        checkOutput("held_first_lat", 32'(lat), 32'd4);
        checkOutput("held_first_rd",  rd3,      32'h12345678);
        we = 1'b1; addr = 7'h0C; wd = 32'h0BADC0DE;
        @(posedge clk); #1;
        req3 = 1'b0;
        lat = 1;
        while (!ready3 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("held_second_lat", 32'(lat), 32'd4);
        applyStimulus(1'b1, 1'b0, 7'h0C, 2'b10, 1'b0, 32'h0, r, f, lat);
        checkOutput("held_readback", r, 32'h0BADC0DE);

        // Reset while a store is waiting: store must be dropped.
        @(negedge clk);
        we = 1'b1; addr = 7'h04; size = 2'b10; wd = 32'hCAFEF00D; req3 = 1'b1;
        @(posedge clk); #1;
        req3 = 1'b0;
        @(posedge clk); #1;
        rst_n3 = 1'b0;
        #1;
        checkOutput("midreset_ready", 32'(ready3), 32'd0);
        checkOutput("midreset_busy",  32'(busy3),  32'd0);
        checkOutput("midreset_rd",    rd3,         32'd0);
        checkOutput("midreset_fault", 32'(fault3), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n3 = 1'b1;
        applyStimulus(1'b1, 1'b0, 7'h04, 2'b10, 1'b0, 32'h0, r, f, lat);
        checkOutput("midreset_readback", r, 32'h12345678);
        checkOutput("midreset_lat", 32'(lat), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
